// File: rtl/note_player.sv
// Note consumer for the song reader handshake: holds one note for a number of
// beats, drives note number and gate, and signals completion with note_done.
module note_player #(
    parameter int NOTE_W         = 6,
    parameter int DUR_W          = 6,
    parameter int STACCATO_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic [2:0]        metadata,
    output logic              note_done,
    output logic [NOTE_W-1:0] note_out,
    output logic              load_freq,
    output logic              gate,
    output logic [DUR_W-1:0]  beats_left,
    output logic              busy,
    output logic              overrun
);

    // ZERO holds a zero-length note for one cycle so its note_done lands two cycles after the strobe
    typedef enum logic [1:0] {IDLE, ZERO, HOLD, DONE} state_t;

    state_t              state, state_n;
    logic [NOTE_W-1:0]   note_q, note_q_n;
    logic [DUR_W-1:0]    dur_q, dur_q_n;
    logic [2:0]          meta_q, meta_q_n;
    logic                note_done_n, load_freq_n, gate_n, busy_n, overrun_n;
    logic [NOTE_W-1:0]   note_out_n;
    logic [DUR_W-1:0]    beats_left_n;
    logic                unused_reserved;

    assign unused_reserved = meta_q[2];

    always_comb begin
        state_n      = state;
        note_q_n     = note_q;
        dur_q_n      = dur_q;
        meta_q_n     = meta_q;
        note_done_n  = 1'b0;
        load_freq_n  = 1'b0;
        gate_n       = 1'b0;
        note_out_n   = note_out;
        beats_left_n = beats_left;
        busy_n       = busy;
        overrun_n    = overrun;
        unique case (state)
            IDLE, DONE: begin
                state_n      = IDLE;
                note_out_n   = '0;
                beats_left_n = '0;
                busy_n       = 1'b0;
                if (new_note) begin
                    note_q_n = note;
                    dur_q_n  = duration;
                    meta_q_n = metadata;
                    if (duration == '0) begin
                        state_n = ZERO;
                    end else begin
                        state_n      = HOLD;
                        beats_left_n = duration;
                        busy_n       = 1'b1;
                        load_freq_n  = 1'b1;
                        note_out_n   = metadata[0] ? '0 : note;
                        gate_n       = play && !metadata[0] &&
                                       (!metadata[1] || duration > (duration >> STACCATO_SHIFT));
                    end
                end
            end
            ZERO: begin
                state_n     = DONE;
                note_done_n = 1'b1;
                load_freq_n = (note_out != '0);
                note_out_n  = '0;
            end
            HOLD: begin
                if (new_note)
                    overrun_n = 1'b1;
                if (beat && play && beats_left == DUR_W'(1)) begin
                    state_n      = DONE;
                    beats_left_n = '0;
                    busy_n       = 1'b0;
                    note_done_n  = 1'b1;
                    load_freq_n  = (note_out != '0);
                    note_out_n   = '0;
                end else begin
                    if (beat && play)
                        beats_left_n = beats_left - DUR_W'(1);
                    note_out_n = meta_q[0] ? '0 : note_q;
                    gate_n     = play && !meta_q[0] &&
                                 (!meta_q[1] || beats_left_n > (dur_q >> STACCATO_SHIFT));
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            note_q     <= '0;
            dur_q      <= '0;
            meta_q     <= '0;
            note_done  <= 1'b0;
            load_freq  <= 1'b0;
            gate       <= 1'b0;
            note_out   <= '0;
            beats_left <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            note_q     <= note_q_n;
            dur_q      <= dur_q_n;
            meta_q     <= meta_q_n;
            note_done  <= note_done_n;
            load_freq  <= load_freq_n;
            gate       <= gate_n;
            note_out   <= note_out_n;
            beats_left <= beats_left_n;
            busy       <= busy_n;
            overrun    <= overrun_n;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: a beat-counting reference model predicts
// output levels and load_freq/note_done events; a monitor checks them.
module tb_note_player;

    logic       clk = 1'b0;
    logic       reset, play, beat, new_note;
    logic [5:0] note, duration;
    logic [2:0] metadata;
    logic       note_done, load_freq, gate, busy, overrun;
    logic [5:0] note_out, beats_left;

    note_player #(.NOTE_W(6), .DUR_W(6), .STACCATO_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
        .note(note), .duration(duration), .metadata(metadata),
        .note_done(note_done), .note_out(note_out), .load_freq(load_freq),
        .gate(gate), .beats_left(beats_left), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          done;
        bit          load;
        int          nout;
    } ev_t;
    ev_t sb[$];

    int unsigned cyc = 0;
    int  checks = 0;
    int  fails  = 0;
    bit  stim_done = 0;

    // Reference model: a note is a count of accepted beats against its length
    typedef enum int {M_IDLE, M_ZERO, M_HOLD, M_DONE} mph_t;
    mph_t ph = M_IDLE;
    int   m_note = 0, m_dur = 0, m_cnt = 0;
    bit   m_rest = 0, m_stacc = 0;
    bit   e_done = 0, e_load = 0, e_gate = 0, e_busy = 0, e_ovr = 0;
    int   e_note = 0, e_left = 0;

    always @(posedge clk) begin
        int prev;
        cyc++;
        prev   = e_note;
        e_done = 0;
        e_load = 0;
        e_gate = 0;
        if (!reset) begin
            ph = M_IDLE; m_note = 0; m_dur = 0; m_cnt = 0; m_rest = 0; m_stacc = 0;
            e_busy = 0; e_ovr = 0; e_note = 0; e_left = 0;
        end else begin
            if ((ph == M_IDLE || ph == M_DONE) && new_note) begin
                m_note = int'(note); m_dur = int'(duration); m_cnt = 0;
                m_rest = metadata[0]; m_stacc = metadata[1];
                if (m_dur == 0) begin
                    ph = M_ZERO; e_note = 0;
                end else begin
                    ph = M_HOLD; e_load = 1; e_note = m_rest ? 0 : m_note;
                end
            end else if (ph == M_IDLE || ph == M_DONE) begin
                ph = M_IDLE; e_note = 0;
            end else if (ph == M_ZERO) begin
                ph = M_DONE; e_done = 1; e_load = (prev != 0); e_note = 0;
            end else begin
                if (new_note) e_ovr = 1;
                if (beat && play) m_cnt++;
                if (m_cnt == m_dur) begin
                    ph = M_DONE; e_done = 1; e_load = (prev != 0); e_note = 0;
                end
            end
            e_busy = (ph == M_HOLD);
            e_left = (ph == M_HOLD) ? m_dur - m_cnt : 0;
            e_gate = (ph == M_HOLD) && play && !m_rest &&
                     (!m_stacc || m_cnt < m_dur - (m_dur >> 1));
        end
        if (e_done || e_load)
            sb.push_back('{cyc: cyc, done: e_done, load: e_load, nout: e_note});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t ev;
        chk("gate", 32'(gate), 32'(e_gate));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("beats_left", 32'(beats_left), 32'(e_left));
        chk("note_out", 32'(note_out), 32'(e_note));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            ev = sb.pop_front();
            chk("missed_event_cycle", cyc, ev.cyc);
        end
        if (note_done === 1'b1 || load_freq === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'({note_done, load_freq}), 32'd0);
            end else begin
                ev = sb.pop_front();
                chk("event_cycle", cyc, ev.cyc);
                chk("event_note_done", 32'(note_done), 32'(ev.done));
                chk("event_load_freq", 32'(load_freq), 32'(ev.load));
                chk("event_note_out", 32'(note_out), 32'(ev.nout));
            end
        end
        if (stim_done) begin
            chk("scoreboard_empty", sb.size(), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
    end

    task automatic tick(input bit r, input bit pl, input bit bt, input bit nn,
                        input logic [5:0] n, input logic [5:0] d, input logic [2:0] m);
        reset = r; play = pl; beat = bt; new_note = nn;
        note = n; duration = d; metadata = m;
        @(negedge clk);
    endtask

    task automatic beats(input int count, input int period, input bit pl);
        for (int i = 0; i < count; i++) begin
            for (int j = 1; j < period; j++) tick(1, pl, 0, 0, 0, 0, 0);
            tick(1, pl, 1, 0, 0, 0, 0);
        end
    endtask

    initial begin
        tick(0, 1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        // basic note, then rest, staccato
        tick(1, 1, 0, 1, 6'd20, 6'd3, 3'b000);
        beats(3, 4, 1); beats(1, 3, 1);
        tick(1, 1, 0, 1, 6'd20, 6'd2, 3'b001);
        beats(3, 4, 1);
        tick(1, 1, 0, 1, 6'd5, 6'd4, 3'b010);
        beats(5, 4, 1);
        // pause: beats while play is low are dropped
        tick(1, 1, 0, 1, 6'd9, 6'd3, 3'b000);
        beats(1, 4, 1); beats(2, 3, 0); beats(3, 4, 1);
        // back-to-back in the note_done cycle, then overrun
        tick(1, 1, 0, 1, 6'd10, 6'd1, 3'b000);
        tick(1, 1, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 1, 6'd7, 6'd1, 3'b000);
        tick(1, 1, 0, 1, 6'd33, 6'd4, 3'b000);
        beats(2, 2, 1);
        // beat coincident with acceptance is not counted
        tick(1, 1, 1, 1, 6'd12, 6'd2, 3'b000);
        beats(3, 3, 1);
        // zero duration, then reset mid-note
        tick(1, 1, 0, 1, 6'd15, 6'd0, 3'b000);
        beats(1, 4, 1);
        tick(1, 1, 0, 1, 6'd40, 6'd5, 3'b000);
        beats(1, 2, 1);
        tick(0, 1, 0, 0, 0, 0, 0);
        beats(2, 3, 1);
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] d;
            d = 6'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) d = 6'($urandom);
            tick($urandom_range(0, 499) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 6'($urandom), d, 3'($urandom));
        end
        tick(1, 1, 0, 0, 0, 0, 0);
        stim_done = 1;
        repeat (4) @(negedge clk);
        $display("FAIL summary_not_reached: got 0 expected 1");
        $fatal(1);
    end

endmodule
